bicubic_tap_mac: RTL



---
 rtl/bicubic_tap_mac.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/bicubic_tap_mac.sv
// Bicubic 4x4 window tap MAC: 4 beats of 4 taps, split pos/neg sums.
// Optional BICUBIC_MAC_ERR_EN adds out_err pulses and a saturating err_cnt.
module bicubic_tap_mac #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 26,
  parameter int TAPS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_start,
  input  logic                     in_bias,
  input  logic [TAPS*PIX_W-1:0]    in_pix,
  input  logic [TAPS*WGT_W-1:0]    in_wgt,
  input  logic [TAPS-1:0]          in_sgn,
  output logic                     out_valid,
  output logic [PIX_W+WGT_W+5:0]   pos_sum,
  output logic [PIX_W+WGT_W+3:0]   neg_sum,
  output logic                     out_bias,
  output logic                     out_err
);

  localparam int PRD_W = PIX_W + WGT_W;
  localparam int PRT_W = PRD_W + 2;
  localparam int ACC_W = PRT_W + 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACC1  = 2'd1,
    ACC2  = 2'd2,
    ACC3  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                  s1_valid;
  logic                  s1_start;
  logic                  s1_bias;
  logic [TAPS*PIX_W-1:0] s1_pix;
  logic [TAPS*WGT_W-1:0] s1_wgt;
  logic [TAPS-1:0]       s1_sgn;

  logic                  beat_take;
  logic                  beat_load;
  logic                  beat_last;
  logic                  beat_err;

  logic [PRD_W-1:0]      prod;
  logic [PRT_W-1:0]      part_pos;
  logic [PRT_W-1:0]      part_neg;

  logic                  s2_take;
  logic                  s2_load;
  logic                  s2_last;
  logic                  s2_bias;
  logic                  s2_err;
  logic [PRT_W-1:0]      s2_pos;
  logic [PRT_W-1:0]      s2_neg;

  logic [ACC_W-1:0]      pos_acc;
  logic [ACC_W-1:0]      neg_acc;
  logic                  bias_acc;
  logic [ACC_W-1:0]      pos_nxt;
  logic [ACC_W-1:0]      neg_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_start <= 1'b0;
      s1_bias  <= 1'b0;
      s1_pix   <= '0;
      s1_wgt   <= '0;
      s1_sgn   <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_start <= in_start;
      s1_bias  <= in_bias;
      s1_pix   <= in_pix;
      s1_wgt   <= in_wgt;
      s1_sgn   <= in_sgn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // A start beat always opens a fresh window; stray beats are dropped.
  always_comb begin
    state_d   = state_q;
    beat_take = 1'b0;
    beat_load = 1'b0;
    beat_last = 1'b0;
    beat_err  = 1'b0;
    if (s1_valid) begin
      if (s1_start) begin
        beat_take = 1'b1;
        beat_load = 1'b1;
        beat_err  = (state_q != EMPTY);
        state_d   = ACC1;
      end else if (state_q == EMPTY) begin
        beat_err  = 1'b1;
      end else begin
        beat_take = 1'b1;
        beat_last = (state_q == ACC3);
        state_d   = state_t'(state_q + 2'd1);
      end
    end
  end

  always_comb begin
    prod     = '0;
    part_pos = '0;
    part_neg = '0;
    for (int i = 0; i < TAPS; i++) begin
      prod = PRD_W'(s1_pix[i*PIX_W +: PIX_W])
           * PRD_W'(s1_wgt[i*WGT_W +: WGT_W]);
      if (s1_sgn[i]) part_neg = part_neg + PRT_W'(prod);
      else           part_pos = part_pos + PRT_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_take <= 1'b0;
      s2_load <= 1'b0;
      s2_last <= 1'b0;
      s2_bias <= 1'b0;
      s2_err  <= 1'b0;
      s2_pos  <= '0;
      s2_neg  <= '0;
    end else begin
      s2_take <= beat_take;
      s2_load <= beat_load;
      s2_last <= beat_last;
      s2_bias <= s1_bias;
      s2_err  <= beat_err;
      s2_pos  <= part_pos;
      s2_neg  <= part_neg;
    end
  end

  always_comb begin
    pos_nxt = (s2_load ? '0 : pos_acc) + ACC_W'(s2_pos);
    neg_nxt = (s2_load ? '0 : neg_acc) + ACC_W'(s2_neg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_acc   <= '0;
      neg_acc   <= '0;
      bias_acc  <= 1'b0;
      out_valid <= 1'b0;
      pos_sum   <= '0;
      neg_sum   <= '0;
      out_bias  <= 1'b0;
    end else begin
      out_valid <= s2_take & s2_last;
      if (s2_take) begin
        pos_acc <= pos_nxt;
        neg_acc <= neg_nxt;
      end
      if (s2_load) bias_acc <= s2_bias;
      if (s2_take & s2_last) begin
        pos_sum  <= {2'b00, pos_nxt};
        neg_sum  <= neg_nxt;
        out_bias <= bias_acc;
      end
    end
  end

`ifdef BICUBIC_MAC_ERR_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      out_err <= s2_err;
      if (s2_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_err;
  assign unused_err = s2_err;
  assign out_err    = 1'b0;
`endif

endmodule
